// File: rtl/gate_controller.sv
// Parking gate controller: debounced entry/exit sensors drive a
// request/response handshake with the parking-management stage.

module gate_debounce #(
  parameter int unsigned CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rise
);

  logic       sync1;
  logic       sync2;
  logic       clean;
  logic       clean_d;
  logic [3:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      clean   <= 1'b0;
      clean_d <= 1'b0;
      cnt     <= 4'd0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      clean_d <= clean;
      if (sync2 == clean) begin
        cnt <= 4'd0;
      end else if (cnt == 4'(CYCLES - 1)) begin
        clean <= sync2;
        cnt   <= 4'd0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  assign rise = clean & ~clean_d;

endmodule

module gate_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned OPEN_CYCLES     = 8,
  parameter int unsigned DENY_CYCLES     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_sensor,
  input  logic       exit_sensor,
  input  logic [1:0] exit_slot_in,
  input  logic       is_open,
  input  logic       is_full,
  output logic       entry_signal,
  output logic       exit_signal,
  output logic [1:0] exit_slot,
  output logic       barrier_up,
  output logic       full_led,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    REQ_ENTRY,
    REQ_EXIT,
    WAIT_RESP,
    OPEN,
    DENY
  } state_t;

  state_t     state;
  logic       ev_entry;
  logic       ev_exit;
  logic       pend_entry;
  logic       pend_exit;
  logic       req_entry;
  logic [7:0] dwell;
  logic       take_exit;
  logic       take_entry;

  gate_debounce #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_entry_db (
    .clk  (clk),
    .reset(reset),
    .raw  (entry_sensor),
    .rise (ev_entry)
  );

  gate_debounce #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_exit_db (
    .clk  (clk),
    .reset(reset),
    .raw  (exit_sensor),
    .rise (ev_exit)
  );

  // exit has priority over entry when both are waiting
  assign take_exit  = (state == IDLE) &&
                      (ev_exit || pend_exit);
  assign take_entry = (state == IDLE) && !take_exit &&
                      (ev_entry || pend_entry);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_entry <= 1'b0;
      pend_exit  <= 1'b0;
    end else begin
      if (take_entry)
        pend_entry <= 1'b0;
      else if (ev_entry)
        pend_entry <= 1'b1;
      if (take_exit)
        pend_exit <= 1'b0;
      else if (ev_exit)
        pend_exit <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      req_entry    <= 1'b0;
      dwell        <= 8'd0;
      entry_signal <= 1'b0;
      exit_signal  <= 1'b0;
      exit_slot    <= 2'b00;
      barrier_up   <= 1'b0;
      full_led     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      entry_signal <= 1'b0;
      exit_signal  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take_exit) begin
            state       <= REQ_EXIT;
            req_entry   <= 1'b0;
            exit_slot   <= exit_slot_in;
            exit_signal <= 1'b1;
            busy        <= 1'b1;
          end else if (take_entry) begin
            state        <= REQ_ENTRY;
            req_entry    <= 1'b1;
            entry_signal <= 1'b1;
            busy         <= 1'b1;
          end
        end
        REQ_ENTRY, REQ_EXIT: begin
          state <= WAIT_RESP;
        end
        WAIT_RESP: begin
          if (is_open) begin
            state      <= OPEN;
            barrier_up <= 1'b1;
            dwell      <= 8'(OPEN_CYCLES);
          end else if (is_full && req_entry) begin
            state    <= DENY;
            full_led <= 1'b1;
            dwell    <= 8'(DENY_CYCLES);
          end else begin
            state     <= IDLE;
            busy      <= 1'b0;
            exit_slot <= 2'b00;
          end
        end
        OPEN, DENY: begin
          if (dwell <= 8'd1) begin
            state      <= IDLE;
            barrier_up <= 1'b0;
            full_led   <= 1'b0;
            busy       <= 1'b0;
            exit_slot  <= 2'b00;
          end else begin
            dwell <= dwell - 8'd1;
          end
        end
        default: begin
          state      <= IDLE;
          barrier_up <= 1'b0;
          full_led   <= 1'b0;
          busy       <= 1'b0;
          exit_slot  <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_controller.sv
// Bench for gate_controller: timing table, directed corner
// sequences and random traffic against a behavioural model.

module tb_gate_controller;

  localparam int DEB = 4;
  localparam int OPN = 8;
  localparam int DNY = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       entry_sensor;
  logic       exit_sensor;
  logic [1:0] exit_slot_in;
  logic       is_open;
  logic       is_full;
  logic       entry_signal;
  logic       exit_signal;
  logic [1:0] exit_slot;
  logic       barrier_up;
  logic       full_led;
  logic       busy;

  always #5 clk = ~clk;

  gate_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .OPEN_CYCLES    (OPN),
    .DENY_CYCLES    (DNY)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .entry_sensor(entry_sensor),
    .exit_sensor (exit_sensor),
    .exit_slot_in(exit_slot_in),
    .is_open     (is_open),
    .is_full     (is_full),
    .entry_signal(entry_signal),
    .exit_signal (exit_signal),
    .exit_slot   (exit_slot),
    .barrier_up  (barrier_up),
    .full_led    (full_led),
    .busy        (busy)
  );

  int vectors = 0;
  int miscompares = 0;

  wire [6:0] dut_out = {entry_signal, exit_signal, exit_slot,
                        barrier_up, full_led, busy};

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_WAIT = 2;
  localparam int M_OPEN = 3;
  localparam int M_DENY = 4;

  int          m_mode;
  int          m_left;
  bit          m_dir_exit;
  logic [1:0]  m_slot;
  bit          m_pend[2];
  bit          m_s1[2];
  bit          m_s2[2];
  bit          m_clean[2];
  bit          m_clean_d[2];
  logic [15:0] m_hist[2];

  function void m_reset();
    m_mode = M_IDLE;
    m_left = 0;
    m_dir_exit = 1'b0;
    m_slot = 2'b00;
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0;
      m_s1[i] = 0;
      m_s2[i] = 0;
      m_clean[i] = 0;
      m_clean_d[i] = 0;
      m_hist[i] = '0;
    end
  endfunction

  function void m_step();
    bit ev[2];
    bit raw[2];
    logic [15:0] mask;
    mask = 16'((1 << DEB) - 1);
    raw[0] = entry_sensor;
    raw[1] = exit_sensor;
    for (int i = 0; i < 2; i++)
      ev[i] = m_clean[i] && !m_clean_d[i];
    if (m_mode != M_IDLE)
      for (int i = 0; i < 2; i++)
        m_pend[i] = m_pend[i] | ev[i];
    case (m_mode)
      M_IDLE: begin
        if (ev[1] || m_pend[1]) begin
          m_mode = M_REQ;
          m_dir_exit = 1'b1;
          m_slot = exit_slot_in;
          m_pend[1] = 0;
          m_pend[0] = m_pend[0] | ev[0];
        end else if (ev[0] || m_pend[0]) begin
          m_mode = M_REQ;
          m_dir_exit = 1'b0;
          m_pend[0] = 0;
        end
      end
      M_REQ: m_mode = M_WAIT;
      M_WAIT: begin
        if (is_open) begin
          m_mode = M_OPEN;
          m_left = OPN;
        end else if (is_full && !m_dir_exit) begin
          m_mode = M_DENY;
          m_left = DNY;
        end else begin
          m_mode = M_IDLE;
        end
      end
      default: begin
        m_left = m_left - 1;
        if (m_left == 0)
          m_mode = M_IDLE;
      end
    endcase
    // level flips once the last DEB synced samples all disagree
    for (int i = 0; i < 2; i++) begin
      m_clean_d[i] = m_clean[i];
      m_hist[i] = {m_hist[i][14:0], m_s2[i]};
      if ((m_hist[i] & mask) == (m_clean[i] ? 16'd0 : mask))
        m_clean[i] = !m_clean[i];
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
    end
  endfunction

  function logic [6:0] m_out();
    logic [6:0] o;
    o = {m_mode == M_REQ && !m_dir_exit,
         m_mode == M_REQ && m_dir_exit,
         (m_mode != M_IDLE && m_dir_exit) ? m_slot : 2'b00,
         m_mode == M_OPEN,
         m_mode == M_DENY,
         m_mode != M_IDLE};
    return o;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int act,
                       input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h",
               name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset)
      m_reset();
    else
      m_step();
    @(negedge clk);
    check("model", int'(dut_out), int'(m_out()));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("reset_now", int'(dut_out), 0);
    m_reset();
    tick();
    reset = 1'b0;
  endtask

  task automatic quiet();
    entry_sensor = 1'b0;
    exit_sensor  = 1'b0;
    exit_slot_in = 2'b00;
    is_open      = 1'b0;
    is_full      = 1'b0;
  endtask

  typedef struct {
    logic       ent;
    logic       ext;
    logic [1:0] slot;
    logic       opn;
    logic       ful;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[20];
  int   hold[2];

  initial begin
    int c_a, c_b, c_c, t_ex, t_en, lat;
    bit idle_seen;
    logic [1:0] s_ex;

    // entry with grant: request at edge 6, barrier edges 8..15
    for (int k = 0; k < 20; k++) begin
      tbl[k].ent  = 1'b1;
      tbl[k].ext  = 1'b0;
      tbl[k].slot = 2'b00;
      tbl[k].opn  = (k == 8);
      tbl[k].ful  = 1'b0;
      tbl[k].exp  = {k == 6, 1'b0, 2'b00,
                     k >= 8 && k <= 15, 1'b0,
                     k >= 6 && k <= 15};
    end

    reset = 1'b1;
    quiet();
    m_reset();
    #2;
    check("reset_state", int'(dut_out), 0);
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;

    do_reset();
    for (int k = 0; k < 20; k++) begin
      entry_sensor = tbl[k].ent;
      exit_sensor  = tbl[k].ext;
      exit_slot_in = tbl[k].slot;
      is_open      = tbl[k].opn;
      is_full      = tbl[k].ful;
      tick();
      check($sformatf("table[%0d]", k), int'(dut_out),
            int'(tbl[k].exp));
    end

    // refused entry
    quiet();
    do_reset();
    entry_sensor = 1'b1;
    is_full = 1'b1;
    c_a = 0;
    c_b = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      c_a += int'(full_led);
      c_b += int'(barrier_up);
    end
    check("deny_led_cycles", c_a, DNY);
    check("deny_barrier_cycles", c_b, 0);
    check("deny_busy_end", int'(busy), 0);

    // simultaneous exit and entry: exit first
    quiet();
    do_reset();
    entry_sensor = 1'b1;
    exit_sensor  = 1'b1;
    exit_slot_in = 2'b10;
    is_open      = 1'b1;
    t_ex = -1;
    t_en = -1;
    s_ex = 2'b00;
    idle_seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (exit_signal && t_ex < 0) begin
        t_ex = k;
        s_ex = exit_slot;
      end
      if (t_ex >= 0 && t_en < 0 && !busy)
        idle_seen = 1;
      if (entry_signal && t_en < 0)
        t_en = k;
    end
    check("both_exit_time", t_ex, 6);
    check("both_exit_slot", int'(s_ex), 2);
    check("both_entry_time", t_en, 6 + 2 + OPN + 1);
    check("both_idle_between", int'(idle_seen), 1);

    // short glitch: no event
    quiet();
    do_reset();
    c_a = 0;
    c_b = 0;
    for (int k = 0; k < 24; k++) begin
      entry_sensor = (k < 3);
      tick();
      c_a += int'(entry_signal);
      c_b += int'(busy);
    end
    check("glitch_requests", c_a, 0);
    check("glitch_busy", c_b, 0);

    // exit neither granted nor refused
    quiet();
    do_reset();
    exit_sensor  = 1'b1;
    exit_slot_in = 2'b01;
    t_ex = -1;
    c_a = 0;
    c_b = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (exit_signal && t_ex < 0)
        t_ex = k;
      c_a += int'(busy);
      c_b += int'(barrier_up) + int'(full_led);
    end
    check("reject_exit_time", t_ex, 6);
    check("reject_busy_cycles", c_a, 2);
    check("reject_barrier", c_b, 0);

    // reset during OPEN, sensor still high
    quiet();
    do_reset();
    entry_sensor = 1'b1;
    is_open = 1'b1;
    for (int k = 0; k < 11; k++)
      tick();
    check("open_before_reset", int'(barrier_up), 1);
    reset = 1'b1;
    #1;
    check("reset_barrier", int'(barrier_up), 0);
    check("reset_busy", int'(busy), 0);
    m_reset();
    tick();
    reset = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (entry_signal && lat == 0)
        lat = n;
    end
    check("post_reset_latency", lat, 7);

    // random traffic against the model
    quiet();
    do_reset();
    hold[0] = 0;
    hold[1] = 0;
    for (int k = 0; k < 4000; k++) begin
      if (hold[0] == 0) begin
        entry_sensor = 1'($urandom_range(0, 1));
        hold[0] = $urandom_range(1, 12);
      end
      if (hold[1] == 0) begin
        exit_sensor = 1'($urandom_range(0, 1));
        hold[1] = $urandom_range(1, 12);
      end
      hold[0]--;
      hold[1]--;
      exit_slot_in = 2'($urandom_range(0, 3));
      is_open = 1'($urandom_range(0, 1));
      is_full = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
